// File: rtl/fp_addmm_arbiter.sv
// Round-robin arbiter/sequencer sharing one pipelined FP add/max/min unit among NREQ requesters.
// Optional performance counters are built when FP_ARB_PERF_EN is defined.
module fp_addmm_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 24,
  parameter int LAT   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [4*NREQ-1:0]     req_op_i,
  input  logic [WIDTH*NREQ-1:0] req_a_i,
  input  logic [WIDTH*NREQ-1:0] req_b_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [WIDTH*NREQ-1:0] rsp_result_o,
  output logic                  fp_valid_o,
  output logic [3:0]            fp_op_o,
  output logic [WIDTH-1:0]      fp_a_o,
  output logic [WIDTH-1:0]      fp_b_o,
  input  logic [WIDTH-1:0]      fp_result_i,
  output logic [31:0]           perf_issue_o,
  output logic [31:0]           perf_stall_o
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Subtraction is an add with the second operand's sign flipped.
  function automatic logic [WIDTH-1:0] cfg_operand_b(input logic [3:0] op,
                                                     input logic [WIDTH-1:0] b);
    if (op[2] && (op[1:0] == 2'b00)) return {~b[WIDTH-1], b[WIDTH-2:0]};
    return b;
  endfunction

  logic [NREQ-1:0]  busy_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] cand;
  logic             grant_vld;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [IDX_W-1:0] iss_idx_p0;
  logic [LAT-1:0]   tag_vld_p1;
  logic [IDX_W-1:0] tag_idx_p1 [LAT];

  always_comb begin
    grant_vld   = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    req_ready_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!grant_vld && req_valid_i[cand] && !busy_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready_o[i]) begin
        op_sel = req_op_i[4*i +: 4];
        a_sel  = req_a_i[WIDTH*i +: WIDTH];
        b_sel  = req_b_i[WIDTH*i +: WIDTH];
      end
    end
    ptr_nxt = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Issue stage (p0): operands to the shared unit, registered on grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      fp_valid_o <= 1'b0;
      fp_op_o    <= '0;
      fp_a_o     <= '0;
      fp_b_o     <= '0;
      iss_idx_p0 <= '0;
    end else begin
      fp_valid_o <= grant_vld;
      if (grant_vld) begin
        rr_ptr_q   <= ptr_nxt;
        fp_op_o    <= {op_sel[3], 1'b0, op_sel[1:0]};
        fp_a_o     <= a_sel;
        fp_b_o     <= cfg_operand_b(op_sel, b_sel);
        iss_idx_p0 <= grant_idx;
      end
    end
  end

  // Tag stage (p1): requester index follows the unit's fixed latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_vld_p1 <= '0;
      for (int k = 0; k < LAT; k++) tag_idx_p1[k] <= '0;
    end else begin
      tag_vld_p1[0] <= fp_valid_o;
      tag_idx_p1[0] <= iss_idx_p0;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_p1[k] <= tag_vld_p1[k-1];
        tag_idx_p1[k] <= tag_idx_p1[k-1];
      end
    end
  end

  // Response stage: one-entry buffer per requester; busy spans issue to handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o  <= '0;
      rsp_result_o <= '0;
      busy_q       <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid_o[i] && rsp_ready_i[i]) begin
          rsp_valid_o[i] <= 1'b0;
          busy_q[i]      <= 1'b0;
        end
        if (tag_vld_p1[LAT-1] && (tag_idx_p1[LAT-1] == IDX_W'(i))) begin
          rsp_valid_o[i]                 <= 1'b1;
          rsp_result_o[WIDTH*i +: WIDTH] <= fp_result_i;
        end
        if (req_ready_o[i]) busy_q[i] <= 1'b1;
      end
    end
  end

`ifdef FP_ARB_PERF_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_vld) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (!grant_vld && |req_valid_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_issue_o = issue_cnt_q;
  assign perf_stall_o = stall_cnt_q;
`else
  assign perf_issue_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_fp_addmm_arbiter.sv
// Scoreboard bench for fp_addmm_arbiter: a stand-in FP unit, a rule-level reference
// model that predicts grants/issues/responses, and a monitor that pops and compares.
module tb_fp_addmm_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 24;
  localparam int LAT   = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [NREQ-1:0]       req_valid_i = '0;
  logic [NREQ-1:0]       req_ready_o;
  logic [4*NREQ-1:0]     req_op_i = '0;
  logic [WIDTH*NREQ-1:0] req_a_i = '0;
  logic [WIDTH*NREQ-1:0] req_b_i = '0;
  logic [NREQ-1:0]       rsp_valid_o;
  logic [NREQ-1:0]       rsp_ready_i = '0;
  logic [WIDTH*NREQ-1:0] rsp_result_o;
  logic                  fp_valid_o;
  logic [3:0]            fp_op_o;
  logic [WIDTH-1:0]      fp_a_o;
  logic [WIDTH-1:0]      fp_b_o;
  logic [WIDTH-1:0]      fp_result_i;
  logic [31:0]           perf_issue_o;
  logic [31:0]           perf_stall_o;

  fp_addmm_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .fp_valid_o(fp_valid_o), .fp_op_o(fp_op_o), .fp_a_o(fp_a_o), .fp_b_o(fp_b_o),
    .fp_result_i(fp_result_i),
    .perf_issue_o(perf_issue_o), .perf_stall_o(perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Stand-in unit: distinct result per op; the op field is folded in so a wrong op is visible.
  function automatic logic [WIDTH-1:0] fu(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op[1:0])
      2'b00:   r = a + b;
      2'b01:   r = (a > b) ? a : b;
      2'b10:   r = (a < b) ? a : b;
      default: return '0;
    endcase
    return r ^ {op, {(WIDTH-4){1'b0}}};
  endfunction

  function automatic logic [WIDTH-1:0] exp_b(input logic [3:0] op, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] sgn;
    sgn = '0;
    sgn[WIDTH-1] = 1'b1;
    return (op == 4'b0100 || op == 4'b1100) ? (b ^ sgn) : b;
  endfunction

  logic [WIDTH-1:0] fu_pipe [LAT];
  always @(posedge clk_i) begin
    for (int k = LAT-1; k > 0; k--) fu_pipe[k] <= fu_pipe[k-1];
    fu_pipe[0] <= fp_valid_o ? fu(fp_op_o, fp_a_o, fp_b_o) : WIDTH'($urandom);
  end
  assign fp_result_i = fu_pipe[LAT-1];

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               cyc;
  } iss_t;
  typedef struct packed {
    logic [WIDTH-1:0] res;
    int               cyc;
  } rsp_t;

  iss_t            iq [$];
  rsp_t            rq [NREQ][$];
  logic [NREQ-1:0] m_busy = '0;
  logic [NREQ-1:0] exp_ready = '0;
  int              m_ptr = 0;
  int              m_issue = 0;
  int              m_stall = 0;
  int              checks = 0;
  int              failures = 0;
  logic            done = 1'b0;
  logic [NREQ-1:0] took = '0;

  // Reference model: grant = first requester at/after the pointer that is valid and idle.
  initial forever begin
    int g, c;
    logic [3:0] op;
    logic [WIDTH-1:0] a, b;
    @(negedge clk_i);
    if (rst_i) begin
      m_busy = '0; m_ptr = 0; m_issue = 0; m_stall = 0; exp_ready = '0;
      iq.delete();
      for (int i = 0; i < NREQ; i++) rq[i].delete();
    end else begin
      exp_ready = '0;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid_i[c] && !m_busy[c]) g = c;
      end
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        op = req_op_i[4*g +: 4];
        a  = req_a_i[WIDTH*g +: WIDTH];
        b  = exp_b(op, req_b_i[WIDTH*g +: WIDTH]);
        iq.push_back('{op: op & 4'b1011, a: a, b: b, cyc: cyc});
        rq[g].push_back('{res: fu(op & 4'b1011, a, b), cyc: cyc});
        m_busy[g] = 1'b1;
        m_ptr = (g + 1) % NREQ;
        m_issue++;
      end else if (|req_valid_i) begin
        m_stall++;
      end
      for (int i = 0; i < NREQ; i++)
        if (rsp_valid_o[i] && rsp_ready_i[i]) m_busy[i] = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  logic [NREQ-1:0]  prev_v = '0;
  logic [NREQ-1:0]  prev_hs = '0;
  logic [WIDTH-1:0] prev_res [NREQ];
  initial forever begin
    iss_t e;
    rsp_t r;
    logic exp_fv, rise, due, hs;
    logic [WIDTH-1:0] res;
    @(negedge clk_i);
    #2;
    if (rst_i) begin
      chk("rst_fp_valid", 64'(fp_valid_o), 64'(0));
      chk("rst_fp_op", 64'(fp_op_o), 64'(0));
      chk("rst_fp_a", 64'(fp_a_o), 64'(0));
      chk("rst_fp_b", 64'(fp_b_o), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
      chk("rst_rsp_result", 64'(rsp_result_o), 64'(0));
      chk("rst_req_ready", 64'(req_ready_o), 64'(req_valid_i));
      chk("rst_perf", 64'({perf_issue_o, perf_stall_o}), 64'(0));
      prev_v = '0;
      prev_hs = '0;
    end else begin
      chk("grant", 64'(req_ready_o), 64'(exp_ready));
      exp_fv = (iq.size() > 0) && (iq[0].cyc == cyc - 1);
      chk("fp_valid", 64'(fp_valid_o), 64'(exp_fv));
      if (exp_fv) begin
        e = iq.pop_front();
        if (fp_valid_o) begin
          chk("fp_op", 64'(fp_op_o), 64'(e.op));
          chk("fp_a", 64'(fp_a_o), 64'(e.a));
          chk("fp_b", 64'(fp_b_o), 64'(e.b));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        res  = rsp_result_o[WIDTH*i +: WIDTH];
        rise = rsp_valid_o[i] && !prev_v[i];
        due  = (rq[i].size() > 0) && (cyc - rq[i][0].cyc == LAT + 2);
        if (rise || due) chk($sformatf("rsp_timing[%0d]", i), 64'(rise), 64'(due));
        if (prev_v[i] && !prev_hs[i]) begin
          chk($sformatf("rsp_hold[%0d]", i), 64'(rsp_valid_o[i]), 64'(1));
          chk($sformatf("rsp_stable[%0d]", i), 64'(res), 64'(prev_res[i]));
        end
        hs = rsp_valid_o[i] && rsp_ready_i[i];
        if (hs) begin
          if (rq[i].size() > 0) begin
            r = rq[i].pop_front();
            chk($sformatf("rsp_result[%0d]", i), 64'(res), 64'(r.res));
          end else begin
            chk($sformatf("rsp_orphan[%0d]", i), 64'(rq[i].size()), 64'(1));
          end
        end
        prev_v[i]   = rsp_valid_o[i];
        prev_hs[i]  = hs;
        prev_res[i] = res;
      end
    end
    if (done) begin
      chk("drain_issue", 64'(iq.size()), 64'(0));
      for (int i = 0; i < NREQ; i++) chk($sformatf("drain_rsp[%0d]", i), 64'(rq[i].size()), 64'(0));
`ifdef FP_ARB_PERF_EN
      chk("perf_issue", 64'(perf_issue_o), 64'(m_issue));
      chk("perf_stall", 64'(perf_stall_o), 64'(m_stall));
`else
      chk("perf_issue_off", 64'(perf_issue_o), 64'(0));
      chk("perf_stall_off", 64'(perf_stall_o), 64'(0));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // Stimulus
  task automatic set_req(input int i, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    req_valid_i[i]            = 1'b1;
    req_op_i[4*i +: 4]        = op;
    req_a_i[WIDTH*i +: WIDTH] = a;
    req_b_i[WIDTH*i +: WIDTH] = b;
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < NREQ; i++)
      if (!req_valid_i[i] && int'($urandom_range(99)) < pct)
        set_req(i, 4'($urandom), WIDTH'($urandom), WIDTH'($urandom));
  endtask

  task automatic step();
    @(negedge clk_i);
    took = req_valid_i & req_ready_o;
    @(posedge clk_i);
    #1;
    req_valid_i = req_valid_i & ~took;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    rsp_ready_i = '1;
    set_req(0, 4'b0000, 24'h3F8000, 24'h400000);
    repeat (8) step();

    set_req(1, 4'b0100, 24'h3F8000, 24'h400000);
    set_req(2, 4'b0101, 24'h3F8000, 24'h400000);
    set_req(3, 4'b1011, 24'h123456, 24'h400000);
    repeat (10) step();

    for (int n = 0; n < 30; n++) begin
      refill(100);
      step();
    end

    rsp_ready_i = '1;
    rsp_ready_i[1] = 1'b0;
    for (int n = 0; n < 12; n++) begin
      refill(100);
      step();
    end
    rsp_ready_i = '1;

    for (int n = 0; n < 1500; n++) begin
      rsp_ready_i = NREQ'($urandom) | NREQ'($urandom);
      refill(50);
      step();
    end

    rsp_ready_i = '1;
    req_valid_i = '0;
    set_req(2, 4'b0000, 24'h3F8000, 24'h400000);
    for (int n = 0; n < 12 && !took[2]; n++) step();
    step();
    rst_i = 1'b1;
    req_valid_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (10) step();

    for (int n = 0; n < 200; n++) begin
      rsp_ready_i = NREQ'($urandom) | NREQ'($urandom);
      refill(60);
      step();
    end

    req_valid_i = '0;
    rsp_ready_i = '1;
    repeat (20) step();
    done = 1'b1;
    repeat (6) @(posedge clk_i);
    $display("FAIL tb_end actual=no_summary required=summary");
    $fatal(1, "bench did not reach its summary");
  end
endmodule
